i_cache: RTL and testbench
==========================

# i_cache

Direct-mapped, read-only instruction cache that responds to instruction fetch requests from the fetch stage and refills lines from a backing instruction memory. It replaces the fetch stage's local instruction memory array. It sits between the fetch stage (responder side) and the memory/bus interface (initiator side). Hits return one cycle after acceptance. Misses stall the fetch interface while a full line is refilled by a beat-by-beat valid/ready transfer.

## Interface
- ADDR_WIDTH, 32, byte-address width on both sides
- INSTR_WIDTH, 32, instruction and memory beat width
- NUM_LINES, 16, cache lines; power of 2, ≥2
- WORDS_PER_LINE, 4, words per line; power of 2, ≥2
- Derived, not overridable:
  - OFFSET_W = log2(WORDS_PER_LINE)+2
  - INDEX_W = log2(NUM_LINES)
  - TAG_W = ADDR_WIDTH-INDEX_W-OFFSET_W
- i_clk  in  1  clock; all logic on rising edge
- i_reset_n  in  1  synchronous, active-low reset
- i_fetch_req  in  1  fetch request valid
- i_fetch_addr  in  ADDR_WIDTH  byte address; bits [1:0] ignored
- o_fetch_ready  out  1  request accepted this cycle when i_fetch_req & o_fetch_ready
- o_fetch_valid  out  1  o_fetch_instr valid; single-cycle pulse per accepted request
- o_fetch_instr  out  INSTR_WIDTH  returned instruction
- i_flush  in  1  invalidate all lines (fence.i)
- o_mem_req_valid  out  1  line refill request
- o_mem_req_addr  out  ADDR_WIDTH  line-aligned address; low OFFSET_W bits zero
- i_mem_req_ready  in  1  memory accepts request
- i_mem_rsp_valid  in  1  refill beat valid; beats arrive in ascending word order
- i_mem_rsp_data  in  INSTR_WIDTH  refill beat data

## Operation
- Address split:
  - tag = addr[ADDR_WIDTH-1 : INDEX_W+OFFSET_W]
  - index = addr[INDEX_W+OFFSET_W-1 : OFFSET_W]
  - word = addr[OFFSET_W-1 : 2]
- Storage:
  - per-line valid bit and tag held in flops
  - data array of NUM_LINES×WORDS_PER_LINE words
- FSM states: IDLE, REQ, FILL, RESP.
- o_fetch_ready = (state==IDLE) & !i_flush.
- IDLE, request accepted:
  - compare the tag and valid bit of the indexed line combinationally
  - hit: register the word; o_fetch_valid=1 next cycle; remain in IDLE
  - miss: latch the address; go to REQ
- REQ:
  - o_mem_req_valid=1; o_mem_req_addr = latched address with offset bits cleared
  - address is held stable until accepted
  - on i_mem_req_ready: go to FILL; clear the beat counter
- FILL:
  - each i_mem_rsp_valid beat writes data[index][beat] and increments the counter
  - the beat whose number equals the latched word is captured as the response
  - on the last beat (counter = WORDS_PER_LINE-1): set tag and valid; go to RESP
- RESP:
  - o_fetch_valid=1 with the captured word for exactly one cycle
  - return to IDLE
- Flush:
  - in IDLE: all valid bits clear at the next edge; any simultaneous request is not accepted
  - in REQ/FILL/RESP: a pending flag is set; the refill and response complete normally
  - all valid bits, including the just-filled line, clear on the RESP→IDLE edge
- i_mem_rsp_valid outside FILL is ignored.
- Requests outside IDLE are not accepted; the requester holds i_fetch_req and i_fetch_addr.

## Timing
- Reset values:
  - state IDLE; all valid bits 0; flush-pending flag 0
  - o_fetch_valid=0, o_fetch_instr=0, o_mem_req_valid=0, o_mem_req_addr=0
  - o_fetch_ready=1 in the first cycle after reset deasserts
- Hit: accepted at cycle N → o_fetch_valid at N+1. Back-to-back hits sustain one per cycle.
- Miss:
  - accepted at N → o_mem_req_valid from N+1
  - if ready at cycle R, beats are counted from R+1
  - last beat at cycle L → o_fetch_valid at L+1; o_fetch_ready returns at L+2
- Minimum miss latency, acceptance to o_fetch_valid: 2 + WORDS_PER_LINE cycles.
- Reset mid-refill:
  - the FSM returns to IDLE at that edge; o_mem_req_valid drops
  - the partially written line stays invalid; later beats are ignored
- o_fetch_instr holds its last value when o_fetch_valid=0.

## Test plan
- Reset, then idle:
  - all outputs 0; o_fetch_ready=1
  - request 0x0000_0000 → o_mem_req_valid next cycle with addr 0x0000_0000
- Cold miss at 0x40 with beats 0x11,0x22,0x33,0x44 and ready immediate:
  - o_fetch_instr=0x11 one cycle after beat 4
  - request 0x44 then hits: 0x22 on the next cycle
- Miss at 0x4C with i_mem_req_ready held low 3 cycles:
  - req_valid and addr 0x40 stay stable throughout
  - response is 0x44 (4th beat)
  - 0x40, 0x44, 0x48, 0x4C issued back-to-back then all hit at 1 per cycle
- Conflict: fill 0x40, then fetch 0x140 (same index 4):
  - the second fetch misses and refills addr 0x140
  - re-fetching 0x40 misses again
- Flush:
  - i_flush asserted during FILL → response still delivered
  - fetching the same address afterward misses
  - i_flush with a simultaneous request in IDLE → o_fetch_ready=0, request not accepted
- Reset asserted during FILL after 2 beats:
  - o_mem_req_valid=0; stray rsp beats ignored
  - subsequent fetch of the same line misses

Source files
------------

// File: rtl/i_cache.sv
// rtl/i_cache.sv - direct-mapped read-only instruction cache with beat-wise line refill
module i_cache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_fetch_req,
  input  logic [ADDR_WIDTH-1:0]  i_fetch_addr,
  output logic                   o_fetch_ready,
  output logic                   o_fetch_valid,
  output logic [INSTR_WIDTH-1:0] o_fetch_instr,
  input  logic                   i_flush,
  output logic                   o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_req_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rsp_data
);

  localparam int WORD_W   = $clog2(WORDS_PER_LINE);
  localparam int OFFSET_W = WORD_W + 2;
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
  localparam int SLOTS    = NUM_LINES * WORDS_PER_LINE;
  localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;
  state_t state_q, state_d;

  logic [NUM_LINES-1:0]   valid_q;
  logic [TAG_W-1:0]       tags [NUM_LINES];
  logic [INSTR_WIDTH-1:0] data_mem [SLOTS];

  logic                   flush_pending_q;
  logic                   fetch_valid_q;
  logic [INSTR_WIDTH-1:0] fetch_instr_q;
  logic [INSTR_WIDTH-1:0] captured_q;
  logic [ADDR_WIDTH-1:0]  line_addr_q;
  logic [WORD_W-1:0]      miss_word_q;
  logic [WORD_W-1:0]      beat_q;

  logic [TAG_W-1:0]   fetch_tag;
  logic [INDEX_W-1:0] fetch_index;
  logic [WORD_W-1:0]  fetch_word;
  logic [TAG_W-1:0]   line_tag;
  logic [INDEX_W-1:0] line_index;
  logic               hit;
  logic               accept;
  logic               fill_beat;
  logic               fill_last;
  logic               unused_addr_bits;

  assign fetch_tag   = i_fetch_addr[ADDR_WIDTH-1 -: TAG_W];
  assign fetch_index = i_fetch_addr[OFFSET_W +: INDEX_W];
  assign fetch_word  = i_fetch_addr[2 +: WORD_W];
  assign line_tag    = line_addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign line_index  = line_addr_q[OFFSET_W +: INDEX_W];
  assign unused_addr_bits = ^i_fetch_addr[1:0];

  assign hit       = valid_q[fetch_index] && (tags[fetch_index] == fetch_tag);
  assign accept    = i_fetch_req && o_fetch_ready;
  assign fill_beat = (state_q == FILL) && i_mem_rsp_valid;
  assign fill_last = fill_beat && (beat_q == LAST_BEAT);

  assign o_fetch_valid  = fetch_valid_q;
  assign o_fetch_instr  = fetch_instr_q;
  assign o_mem_req_addr = line_addr_q;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    o_fetch_ready   = 1'b0;
    o_mem_req_valid = 1'b0;
    case (state_q)
      IDLE: begin
        o_fetch_ready = !i_flush;
        if (i_fetch_req && !i_flush && !hit) begin
          state_d = REQ;
        end
      end
      REQ: begin
        o_mem_req_valid = 1'b1;
        if (i_mem_req_ready) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (fill_last) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Storage arrays carry no reset; valid_q alone decides whether their contents count.
  always_ff @(posedge i_clk) begin
    if (i_reset_n && fill_beat) begin
      data_mem[{line_index, beat_q}] <= i_mem_rsp_data;
      if (beat_q == LAST_BEAT) begin
        tags[line_index] <= line_tag;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      fetch_valid_q   <= 1'b0;
      fetch_instr_q   <= '0;
      captured_q      <= '0;
      line_addr_q     <= '0;
      miss_word_q     <= '0;
      beat_q          <= '0;
    end else begin
      fetch_valid_q <= 1'b0;
      if (state_q == RESP) begin
        flush_pending_q <= 1'b0;
      end else if (i_flush && state_q != IDLE) begin
        flush_pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (i_flush) begin
            valid_q <= '0;
          end else if (accept && hit) begin
            fetch_valid_q <= 1'b1;
            fetch_instr_q <= data_mem[{fetch_index, fetch_word}];
          end else if (accept) begin
            line_addr_q <= {fetch_tag, fetch_index, {OFFSET_W{1'b0}}};
            miss_word_q <= fetch_word;
          end
        end
        REQ: begin
          if (i_mem_req_ready) begin
            beat_q <= '0;
          end
        end
        FILL: begin
          if (fill_beat) begin
            beat_q <= beat_q + WORD_W'(1);
            if (beat_q == miss_word_q) begin
              captured_q <= i_mem_rsp_data;
            end
            if (beat_q == LAST_BEAT) begin
              valid_q[line_index] <= 1'b1;
              fetch_valid_q       <= 1'b1;
              fetch_instr_q       <= (beat_q == miss_word_q) ? i_mem_rsp_data : captured_q;
            end
          end
        end
        RESP: begin
          // A flush seen at any point during the refill also drops the line just filled.
          if (flush_pending_q || i_flush) begin
            valid_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_cache.sv
// tb/tb_i_cache.sv - self-checking bench for i_cache against a transaction-level cache model
module tb_i_cache;

  logic        clk;
  logic        reset_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        flush;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;

  i_cache dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_fetch_req     (fetch_req),
    .i_fetch_addr    (fetch_addr),
    .o_fetch_ready   (fetch_ready),
    .o_fetch_valid   (fetch_valid),
    .o_fetch_instr   (fetch_instr),
    .i_flush         (flush),
    .o_mem_req_valid (mem_req_valid),
    .o_mem_req_addr  (mem_req_addr),
    .i_mem_req_ready (mem_req_ready),
    .i_mem_rsp_valid (mem_rsp_valid),
    .i_mem_rsp_data  (mem_rsp_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // reference cache: which line holds which tag
  bit          m_valid [16];
  logic [23:0] m_tag   [16];

  // memory responder state
  bit          mem_busy;
  logic [31:0] mem_line;
  int          mem_beat;
  int          hold_left;
  bit          gaps;
  bit          req_seen;
  logic [31:0] req_addr_seen;
  int          req_first_cyc;
  int          req_cycles;
  bit          addr_unstable;
  int          last_beat_cyc;

  typedef struct {
    logic [31:0] addr;
    int          hold;
    bit          gp;
    int          flush_cyc;
    bit          exp_miss;
    logic [31:0] exp_instr;
    logic [31:0] exp_req;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'hCAFE_0000;
      32'h0000_0004: return 32'hCAFE_0004;
      32'h0000_0040: return 32'h0000_0011;
      32'h0000_0044: return 32'h0000_0022;
      32'h0000_0048: return 32'h0000_0033;
      32'h0000_004C: return 32'h0000_0044;
      32'h0000_0140: return 32'h0000_0055;
      32'h0000_0144: return 32'h0000_0066;
      32'h0000_0148: return 32'h0000_0077;
      32'h0000_014C: return 32'h0000_0088;
      default:       return {a[15:0], ~a[31:16]} ^ 32'h3C3C_A5A5;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  task automatic drive_mem();
    mem_req_ready = (hold_left == 0);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (mem_busy && !(gaps && $urandom_range(0, 2) == 0)) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_rd(mem_line + 32'(4 * mem_beat));
    end
  endtask

  task automatic observe_mem(input int cyc);
    bit was_busy;
    was_busy = mem_busy;
    if (was_busy && mem_rsp_valid) begin
      mem_beat++;
      if (mem_beat == 4) begin
        mem_busy      = 1'b0;
        last_beat_cyc = cyc;
      end
    end
    if (mem_req_valid) begin
      req_cycles++;
      if (!req_seen) begin
        req_seen      = 1'b1;
        req_addr_seen = mem_req_addr;
        req_first_cyc = cyc;
      end else if (mem_req_addr !== req_addr_seen) begin
        addr_unstable = 1'b1;
      end
      if (mem_req_ready && !was_busy) begin
        mem_busy = 1'b1;
        mem_line = mem_req_addr;
        mem_beat = 0;
      end else if (hold_left > 0) begin
        hold_left--;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    check("rst_fetch_instr", fetch_instr, 32'd0);
    check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_mem_req_addr", mem_req_addr, 32'd0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    model_clear();
    mem_busy = 1'b0;
    hold_left = 0;
    gaps = 1'b0;
  endtask

  task automatic run_fetch(input logic [31:0] addr, input int hold, input bit gp, input int flush_cyc,
                           output logic [31:0] got, output bit missed, output logic [31:0] req_addr);
    int          idx;
    logic [23:0] tag;
    bit          exp_hit;
    logic [31:0] exp_instr;
    bit          accepted;
    int          valid_cyc;
    bit          ready_at_valid;
    bit          flushed;
    idx       = int'(addr[7:4]);
    tag       = addr[31:8];
    exp_hit   = m_valid[idx] && (m_tag[idx] == tag);
    exp_instr = mem_rd({addr[31:2], 2'b00});
    accepted = 1'b0; valid_cyc = -1; ready_at_valid = 1'b0; flushed = 1'b0;
    hold_left = hold; gaps = gp; req_seen = 1'b0; req_addr_seen = '0;
    req_first_cyc = -1; req_cycles = 0; addr_unstable = 1'b0; last_beat_cyc = -1;
    got = '0;
    for (int w = 0; w < 10 && !accepted; w++) begin
      @(posedge clk); #1;
      fetch_req = 1'b1; fetch_addr = addr; flush = 1'b0;
      drive_mem();
      #1;
      accepted = fetch_ready;
    end
    check("accept", 32'(accepted), 32'd1);
    for (int cyc = 1; cyc <= 200 && valid_cyc < 0; cyc++) begin
      @(posedge clk); #1;
      fetch_req = 1'b0;
      flush = (cyc == flush_cyc);
      if (flush) flushed = 1'b1;
      drive_mem();
      #1;
      if (fetch_valid) begin
        valid_cyc      = cyc;
        got            = fetch_instr;
        ready_at_valid = fetch_ready;
      end
      observe_mem(cyc);
    end
    @(posedge clk); #1;
    fetch_req = 1'b0; flush = 1'b0;
    drive_mem();
    #1;
    check("valid_single_pulse", 32'(fetch_valid), 32'd0);
    check("ready_after_resp", 32'(fetch_ready), 32'd1);
    check("valid_seen", 32'(valid_cyc >= 0), 32'd1);
    check("instr", got, exp_instr);
    check("hit_or_miss", 32'(req_seen), 32'(!exp_hit));
    if (!exp_hit) begin
      check("req_latency", 32'(req_first_cyc), 32'd1);
      check("req_addr", req_addr_seen, {addr[31:4], 4'h0});
      check("req_addr_stable", 32'(addr_unstable), 32'd0);
      check("req_valid_cycles", 32'(req_cycles), 32'(hold + 1));
      check("miss_resp_timing", 32'(valid_cyc), 32'(last_beat_cyc + 1));
      check("ready_low_in_resp", 32'(ready_at_valid), 32'd0);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
    end else begin
      check("hit_latency", 32'(valid_cyc), 32'd1);
    end
    if (flushed) model_clear();
    missed   = req_seen;
    req_addr = req_addr_seen;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] ra;
    bit          missed;
    logic [23:0] tag_tbl [3];

    vecs[0]  = '{32'h0000_0000, 0, 1'b0, 0, 1'b1, 32'hCAFE_0000, 32'h0000_0000};
    vecs[1]  = '{32'h0000_0040, 0, 1'b0, 0, 1'b1, 32'h0000_0011, 32'h0000_0040};
    vecs[2]  = '{32'h0000_0044, 0, 1'b0, 0, 1'b0, 32'h0000_0022, 32'h0000_0000};
    vecs[3]  = '{32'h0000_004C, 0, 1'b0, 0, 1'b0, 32'h0000_0044, 32'h0000_0000};
    vecs[4]  = '{32'h0000_0140, 0, 1'b0, 0, 1'b1, 32'h0000_0055, 32'h0000_0140};
    vecs[5]  = '{32'h0000_004C, 3, 1'b0, 0, 1'b1, 32'h0000_0044, 32'h0000_0040};
    vecs[6]  = '{32'h0000_014E, 3, 1'b1, 0, 1'b1, 32'h0000_0088, 32'h0000_0140};
    vecs[7]  = '{32'h0000_0048, 0, 1'b1, 0, 1'b1, 32'h0000_0033, 32'h0000_0040};
    vecs[8]  = '{32'h0000_004B, 0, 1'b0, 0, 1'b0, 32'h0000_0033, 32'h0000_0000};
    vecs[9]  = '{32'h0000_0004, 0, 1'b0, 0, 1'b0, 32'hCAFE_0004, 32'h0000_0000};
    vecs[10] = '{32'h0000_0144, 0, 1'b0, 3, 1'b1, 32'h0000_0066, 32'h0000_0140};
    vecs[11] = '{32'h0000_0144, 0, 1'b0, 0, 1'b1, 32'h0000_0066, 32'h0000_0140};
    vecs[12] = '{32'h0000_0040, 0, 1'b0, 0, 1'b1, 32'h0000_0011, 32'h0000_0040};
    tag_tbl[0] = 24'h00_0000;
    tag_tbl[1] = 24'h00_0001;
    tag_tbl[2] = 24'h0A_BCDE;

    do_reset();

    for (int i = 0; i < 13; i++) begin
      run_fetch(vecs[i].addr, vecs[i].hold, vecs[i].gp, vecs[i].flush_cyc, got, missed, ra);
      check($sformatf("tbl%0d_instr", i), got, vecs[i].exp_instr);
      check($sformatf("tbl%0d_miss", i), 32'(missed), 32'(vecs[i].exp_miss));
      if (vecs[i].exp_miss) check($sformatf("tbl%0d_req_addr", i), ra, vecs[i].exp_req);
    end

    // line 0x40 is resident: four back-to-back hits, one per cycle
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      fetch_req = (k < 4); fetch_addr = 32'h40 + 32'(4 * k); flush = 1'b0;
      drive_mem();
      #1;
      if (k < 4) check("b2b_ready", 32'(fetch_ready), 32'd1);
      if (k > 0) begin
        check("b2b_valid", 32'(fetch_valid), 32'd1);
        check("b2b_instr", fetch_instr, mem_rd(32'h40 + 32'(4 * (k - 1))));
      end
    end

    // flush with a simultaneous request in IDLE
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 32'h44; flush = 1'b1;
    drive_mem();
    #1;
    check("flush_idle_ready_low", 32'(fetch_ready), 32'd0);
    @(posedge clk); #1;
    fetch_req = 1'b0; flush = 1'b0;
    drive_mem();
    #1;
    check("flush_idle_no_valid", 32'(fetch_valid), 32'd0);
    check("flush_idle_no_req", 32'(mem_req_valid), 32'd0);
    model_clear();
    run_fetch(32'h44, 0, 1'b0, 0, got, missed, ra);
    check("flush_idle_then_miss", 32'(missed), 32'd1);
    check("flush_idle_then_instr", got, 32'h22);

    // reset during FILL after two beats
    @(posedge clk); #1;
    fetch_req = 1'b1; fetch_addr = 32'h80; flush = 1'b0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
    #1;
    check("rf_accept", 32'(fetch_ready), 32'd1);
    @(posedge clk); #1;
    fetch_req = 1'b0;
    #1;
    check("rf_req_valid", 32'(mem_req_valid), 32'd1);
    check("rf_req_addr", mem_req_addr, 32'h80);
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBEEF_0000 + 32'(b);
    end
    @(posedge clk); #1;
    reset_n = 1'b0; mem_rsp_data = 32'hBEEF_0002;
    @(posedge clk); #1;
    reset_n = 1'b1; mem_rsp_data = 32'hBEEF_0003;
    #1;
    check("rf_req_valid_dropped", 32'(mem_req_valid), 32'd0);
    check("rf_ready_after_reset", 32'(fetch_ready), 32'd1);
    check("rf_no_valid", 32'(fetch_valid), 32'd0);
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      mem_rsp_valid = (s < 2); mem_rsp_data = 32'hBEEF_0004 + 32'(s);
      #1;
      check("rf_stray_beat_ignored", 32'(fetch_valid), 32'd0);
      check("rf_stray_ready", 32'(fetch_ready), 32'd1);
    end
    model_clear();
    mem_busy = 1'b0;
    run_fetch(32'h84, 0, 1'b0, 0, got, missed, ra);
    check("rf_refetch_miss", 32'(missed), 32'd1);
    check("rf_refetch_addr", ra, 32'h80);

    // randomized traffic over three tags competing for all sixteen lines
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int          fc;
      a  = {tag_tbl[$urandom_range(0, 2)], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
      fc = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_fetch(a, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), fc, got, missed, ra);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
